// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared types and constants for the parking sensor path
// Purpose: ranger state encoding, distance width/sentinel and the car-present
//          threshold shared with the occupancy counter.
// Ports:   none (package).
package parking_pkg;

  localparam int DIST_W = 13;
  localparam logic [DIST_W-1:0] FAR_VALUE = 13'h1FFF;
  localparam logic [DIST_W-1:0] PRESENT_CM = 13'd60;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRIG      = 3'd1,
    WAIT_RISE = 3'd2,
    MEASURE   = 3'd3,
    HOLDOFF   = 3'd4
  } ranger_state_t;

  // FAR_VALUE is well above the threshold, so a missing echo reads as "empty".
  function automatic logic car_present(input logic [DIST_W-1:0] cm);
    return (cm < PRESENT_CM);
  endfunction

endpackage

// File: rtl/echo_sync.sv
// rtl/echo_sync.sv - 2-FF synchroniser with registered rise/fall detection
// Purpose: bring an asynchronous level into the clock domain and flag its edges.
// Ports:   i_clk, i_rst_n (async, active-low), i_async (raw input),
//          o_sync (synchronised level), o_rise / o_fall (one-cycle edge flags).
module echo_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/hcsr04_ranger.sv
// rtl/hcsr04_ranger.sv - HC-SR04 trigger generator and echo-width-to-cm converter
// Purpose: fire a trigger every PERIOD_CYCLES, time the echo pulse and report
//          floor(width / CYC_PER_CM) in cm, or FAR_VALUE on no echo / overrange.
// Ports:   sys_clk, sys_rst (async, active-low), echo (async sensor pin),
//          trig (sensor trigger), data (distance, held), data_valid (pulse),
//          timeout (pulse when data is FAR_VALUE).
module hcsr04_ranger
  import parking_pkg::*;
#(
  parameter int TRIG_CYCLES   = 500,
  parameter int CYC_PER_CM    = 2900,
  parameter int PERIOD_CYCLES = 3_000_000,
  parameter int RISE_TIMEOUT  = 250_000,
  parameter int MAX_CM        = 400
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              echo,
  output logic              trig,
  output logic [DIST_W-1:0] data,
  output logic              data_valid,
  output logic              timeout
);

  localparam int PER_W   = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int CNT_MAX = (TRIG_CYCLES > RISE_TIMEOUT) ? TRIG_CYCLES : RISE_TIMEOUT;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int SUB_W   = (CYC_PER_CM > 1) ? $clog2(CYC_PER_CM) : 1;

  localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(PERIOD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0]  RISE_LAST = CNT_W'(RISE_TIMEOUT - 1);
  localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(CYC_PER_CM - 1);
  localparam logic [DIST_W-1:0] CM_LIMIT  = DIST_W'(MAX_CM);

  logic w_echo;
  logic w_rise;
  logic w_fall;

  echo_sync u_echo_sync (
    .i_clk   (sys_clk),
    .i_rst_n (sys_rst),
    .i_async (echo),
    .o_sync  (w_echo),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  // Free-running period counter; its wrap to 0 is the only start condition.
  logic [PER_W-1:0] r_period;
  logic             w_period_zero;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_period <= '0;
    end else if (r_period == PER_LAST) begin
      r_period <= '0;
    end else begin
      r_period <= r_period + 1'b1;
    end
  end

  assign w_period_zero = (r_period == '0);

  ranger_state_t     r_state, w_state_nxt;
  logic              r_trig, w_trig_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [SUB_W-1:0]  r_sub, w_sub_nxt;
  logic [DIST_W-1:0] r_cm, w_cm_nxt;
  logic [DIST_W-1:0] r_data, w_data_nxt;
  logic              r_valid, w_valid_nxt;
  logic              r_timeout, w_timeout_nxt;

  // The cm count including this cycle's wrap, so a fall coinciding with the
  // wrap reports the incremented value.
  logic              w_wrap;
  logic [DIST_W-1:0] w_cm_step;
  logic              w_over;

  assign w_wrap    = (r_sub == SUB_LAST);
  assign w_cm_step = w_wrap ? (r_cm + 1'b1) : r_cm;
  assign w_over    = (w_cm_step > CM_LIMIT);

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state   <= IDLE;
      r_trig    <= 1'b0;
      r_cnt     <= '0;
      r_sub     <= '0;
      r_cm      <= '0;
      r_data    <= FAR_VALUE;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_trig    <= w_trig_nxt;
      r_cnt     <= w_cnt_nxt;
      r_sub     <= w_sub_nxt;
      r_cm      <= w_cm_nxt;
      r_data    <= w_data_nxt;
      r_valid   <= w_valid_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_trig_nxt    = r_trig;
    w_cnt_nxt     = r_cnt;
    w_sub_nxt     = r_sub;
    w_cm_nxt      = r_cm;
    w_data_nxt    = r_data;
    w_valid_nxt   = 1'b0;
    w_timeout_nxt = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_period_zero) begin
          w_state_nxt = TRIG;
          w_trig_nxt  = 1'b1;
          w_cnt_nxt   = '0;
        end
      end

      TRIG: begin
        if (r_cnt == TRIG_LAST) begin
          w_state_nxt = WAIT_RISE;
          w_trig_nxt  = 1'b0;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      WAIT_RISE: begin
        if (w_rise) begin
          w_state_nxt = MEASURE;
          w_sub_nxt   = '0;
          w_cm_nxt    = '0;
        end else if (r_cnt == RISE_LAST) begin
          w_state_nxt   = HOLDOFF;
          w_data_nxt    = FAR_VALUE;
          w_valid_nxt   = 1'b1;
          w_timeout_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end

      MEASURE: begin
        w_sub_nxt = w_wrap ? '0 : (r_sub + 1'b1);
        w_cm_nxt  = w_cm_step;
        // Overrange wins even when the fall lands on the wrap, so data never
        // leaves 0..MAX_CM or FAR_VALUE.
        if (w_over) begin
          w_state_nxt   = HOLDOFF;
          w_data_nxt    = FAR_VALUE;
          w_valid_nxt   = 1'b1;
          w_timeout_nxt = 1'b1;
        end else if (w_fall) begin
          w_state_nxt = HOLDOFF;
          w_data_nxt  = w_cm_step;
          w_valid_nxt = 1'b1;
        end
      end

      HOLDOFF: begin
        // A stuck-high echo keeps us here so the sensor is not re-triggered.
        if (!w_echo && w_period_zero) begin
          w_state_nxt = TRIG;
          w_trig_nxt  = 1'b1;
          w_cnt_nxt   = '0;
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_trig_nxt  = 1'b0;
      end
    endcase
  end

  assign trig       = r_trig;
  assign data       = r_data;
  assign data_valid = r_valid;
  assign timeout    = r_timeout;

endmodule
